cp0_regfile: RTL and testbench

Coprocessor-0 register file and exception/ERET controller. Sits directly downstream of the WB stage: consumes `ws_to_c0_bus_t` and MTC0/MFC0 accesses over `WB_C0_Interface`, and produces the pipeline flush request, flush target PC, and interrupt-pending signal. Implements Status, Cause, EPC, BadVAddr, Count and Compare, including the timer interrupt. TLB registers are outside this block.

---
 rtl/cp0_regfile_pkg.sv | 53 +++++
 rtl/cp0_regfile_timer.sv | 60 ++++++
 rtl/cp0_regfile.sv | 143 ++++++++++++++
 tb/tb_cp0_regfile.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, vectors and
// the packed register layouts used by the register file and its timer.
package cp0_regfile_pkg;

  localparam logic [4:0] CR_BADVADDR = 5'd8;
  localparam logic [4:0] CR_COUNT    = 5'd9;
  localparam logic [4:0] CR_COMPARE  = 5'd11;
  localparam logic [4:0] CR_STATUS   = 5'd12;
  localparam logic [4:0] CR_CAUSE    = 5'd13;
  localparam logic [4:0] CR_EPC      = 5'd14;

  localparam logic [4:0] EXCCODE_INT  = 5'h00;
  localparam logic [4:0] EXCCODE_MOD  = 5'h01;
  localparam logic [4:0] EXCCODE_TLBL = 5'h02;
  localparam logic [4:0] EXCCODE_TLBS = 5'h03;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;
  localparam logic [4:0] EXCCODE_SYS  = 5'h08;

  localparam logic [31:0] EXC_VEC_REFILL  = 32'hBFC0_0200;
  localparam logic [31:0] EXC_VEC_GENERAL = 32'hBFC0_0380;

  typedef struct packed {
    logic [7:0] im;
    logic       exl;
    logic       ie;
  } cp0_status_t;

  // ti lives in the timer; the stored Cause holds only the other fields.
  typedef struct packed {
    logic       bd;
    logic [7:0] ip;
    logic [4:0] exccode;
  } cp0_cause_t;

  typedef struct packed {
    cp0_status_t status;
    cp0_cause_t  cause;
    logic        ti;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
  } cp0_regs_t;

  // Address-class exceptions that latch the faulting virtual address.
  function automatic logic exc_sets_badvaddr(input logic [4:0] code);
    return (code == EXCCODE_ADEL) || (code == EXCCODE_ADES) ||
           (code == EXCCODE_TLBL) || (code == EXCCODE_TLBS) ||
           (code == EXCCODE_MOD);
  endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// CP0 Count/Compare timer: Count advances every second cycle, ti latches
// when the updated Count equals Compare and clears on a Compare write.
module cp0_timer
  import cp0_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q, tick_d;
  logic        ti_q, ti_d;

  // Next-state: a Count write overrides the increment; a Compare write overrides a match.
  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    tick_d    = ~tick_q;
    ti_d      = ti_q;
    if (count_we_i) begin
      count_d = wdata_i;
      tick_d  = 1'b0;
    end else if (tick_q) begin
      count_d = count_q + 32'd1;
    end
    if (compare_we_i) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end else if (count_d == compare_q) begin
      ti_d = 1'b1;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q   <= '0;
      compare_q <= '0;
      tick_q    <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      tick_q    <= tick_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file and exception/ERET controller downstream of WB.
// Interface and bus structs are flattened into plain ports.
module cp0_regfile
  import cp0_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_we,
  input  logic [7:0]  wb_addr,
  input  logic [31:0] wb_wdata,
  output logic [31:0] wb_rdata,
  input  logic        ws_eret_flush,
  input  logic        ws_ex,
  input  logic        ws_bd,
  input  logic [4:0]  ws_exccode,
  input  logic        ws_tlb_refill,
  input  logic [31:0] ws_badvaddr,
  input  logic [31:0] ws_pc,
  input  logic [5:0]  ext_int_in,
  output logic        flush_ex,
  output logic        flush_eret,
  output logic        flush_tlb_refill,
  output logic        flush_tlb_op,
  output logic [31:0] flush_target,
  output logic        int_pending
);

  cp0_status_t status_q, status_d;
  cp0_cause_t  cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count, compare;
  logic        ti;
  logic        sel0, wr_en, eret;
  logic [4:0]  regno;
  cp0_regs_t   regs;
  logic [31:0] rdata;
  logic [31:0] target;

  assign regno = wb_addr[4:0];
  assign sel0  = (wb_addr[7:5] == 3'd0);
  // An exception in the same cycle drops the MTC0.
  assign wr_en = wb_we & sel0 & ~ws_ex;
  assign eret  = ws_eret_flush & ~ws_ex;

  cp0_timer u_timer (
    .clk          (clk),
    .resetn       (resetn),
    .count_we_i   (wr_en && (regno == CR_COUNT)),
    .compare_we_i (wr_en && (regno == CR_COMPARE)),
    .wdata_i      (wb_wdata),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );

  // Next-state: MTC0, then ERET, then exception, so later sources take priority.
  always_comb begin
    status_d          = status_q;
    cause_d           = cause_q;
    epc_d             = epc_q;
    badvaddr_d        = badvaddr_q;
    cause_d.ip[7:2]   = {ext_int_in[5] | ti, ext_int_in[4:0]};
    if (wr_en) begin
      case (regno)
        CR_STATUS: begin
          status_d.im  = wb_wdata[15:8];
          status_d.exl = wb_wdata[1];
          status_d.ie  = wb_wdata[0];
        end
        CR_CAUSE: cause_d.ip[1:0] = wb_wdata[9:8];
        CR_EPC:   epc_d = wb_wdata;
        default: ;
      endcase
    end
    if (eret) status_d.exl = 1'b0;
    if (ws_ex) begin
      if (!status_q.exl) begin
        epc_d      = ws_bd ? (ws_pc - 32'd4) : ws_pc;
        cause_d.bd = ws_bd;
      end
      status_d.exl    = 1'b1;
      cause_d.exccode = ws_exccode;
      if (exc_sets_badvaddr(ws_exccode)) badvaddr_d = ws_badvaddr;
    end
  end

  // CP0 architectural registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_q   <= '0;
      cause_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  assign regs = '{status: status_q, cause: cause_q, ti: ti, epc: epc_q,
                  badvaddr: badvaddr_q, count: count, compare: compare};

  // MFC0 read mux over the current register snapshot.
  always_comb begin
    rdata = '0;
    if (sel0) begin
      case (regno)
        CR_STATUS:   rdata = {9'd0, 1'b1, 6'd0, regs.status.im, 6'd0,
                              regs.status.exl, regs.status.ie};
        CR_CAUSE:    rdata = {regs.cause.bd, regs.ti, 14'd0, regs.cause.ip,
                              1'b0, regs.cause.exccode, 2'b00};
        CR_EPC:      rdata = regs.epc;
        CR_BADVADDR: rdata = regs.badvaddr;
        CR_COUNT:    rdata = regs.count;
        CR_COMPARE:  rdata = regs.compare;
        default:     rdata = '0;
      endcase
    end
  end

  // Redirect target from the in-flight exception/ERET and the pre-update exl.
  always_comb begin
    target = '0;
    if (ws_ex) begin
      target = (ws_tlb_refill && !status_q.exl) ? EXC_VEC_REFILL : EXC_VEC_GENERAL;
    end else if (ws_eret_flush) begin
      target = epc_q;
    end
  end

  assign wb_rdata         = resetn ? rdata : '0;
  assign flush_ex         = resetn & ws_ex;
  assign flush_eret       = resetn & eret;
  assign flush_tlb_refill = resetn & ws_ex & ws_tlb_refill;
  assign flush_tlb_op     = 1'b0;
  assign flush_target     = resetn ? target : '0;
  assign int_pending      = status_q.ie & ~status_q.exl &
                            (|(cause_q.ip & status_q.im));

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile.
module tb_cp0_regfile;
  import cp0_regfile_pkg::*;

  logic        clk;
  logic        resetn;
  logic        wb_we;
  logic [7:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic [31:0] wb_rdata;
  logic        ws_eret_flush, ws_ex, ws_bd, ws_tlb_refill;
  logic [4:0]  ws_exccode;
  logic [31:0] ws_badvaddr, ws_pc;
  logic [5:0]  ext_int_in;
  logic        flush_ex, flush_eret, flush_tlb_refill, flush_tlb_op;
  logic [31:0] flush_target;
  logic        int_pending;

  int unsigned checks = 0;
  int unsigned errors = 0;

  cp0_regfile dut (
    .clk              (clk),
    .resetn           (resetn),
    .wb_we            (wb_we),
    .wb_addr          (wb_addr),
    .wb_wdata         (wb_wdata),
    .wb_rdata         (wb_rdata),
    .ws_eret_flush    (ws_eret_flush),
    .ws_ex            (ws_ex),
    .ws_bd            (ws_bd),
    .ws_exccode       (ws_exccode),
    .ws_tlb_refill    (ws_tlb_refill),
    .ws_badvaddr      (ws_badvaddr),
    .ws_pc            (ws_pc),
    .ext_int_in       (ext_int_in),
    .flush_ex         (flush_ex),
    .flush_eret       (flush_eret),
    .flush_tlb_refill (flush_tlb_refill),
    .flush_tlb_op     (flush_tlb_op),
    .flush_target     (flush_target),
    .int_pending      (int_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    wb_addr = addr;
    #1;
    check(tag, wb_rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    wb_we    = 1'b1;
    wb_addr  = {3'd0, addr};
    wb_wdata = data;
    step();
    wb_we    = 1'b0;
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, flush_ex, flush_eret, flush_tlb_refill};
  endfunction

  task automatic ti_chk(input string tag, input logic exp);
    wb_addr = {3'd0, CR_CAUSE};
    #1;
    check(tag, {31'd0, wb_rdata[30]}, {31'd0, exp});
  endtask

  initial begin
    resetn = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_wdata = '0;
    ws_eret_flush = 1'b0; ws_ex = 1'b0; ws_bd = 1'b0; ws_tlb_refill = 1'b0;
    ws_exccode = '0; ws_badvaddr = '0; ws_pc = '0; ext_int_in = '0;

    repeat (3) step();
    rd("status_in_reset", {3'd0, CR_STATUS}, 32'h0);
    check("intp_in_reset", {31'd0, int_pending}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    rd("status_reset", {3'd0, CR_STATUS}, 32'h0040_0000);
    rd("count_reset", {3'd0, CR_COUNT}, 32'h0);
    step(); step();
    rd("count_2cyc", {3'd0, CR_COUNT}, 32'h1);
    step(); step();
    rd("count_4cyc", {3'd0, CR_COUNT}, 32'h2);
    rd("unimpl_reg", 8'd5, 32'h0);
    rd("sel1_status", {3'd1, CR_STATUS}, 32'h0);

    // Timer interrupt
    mtc0(CR_COMPARE, 32'd5);
    rd("compare_rd", {3'd0, CR_COMPARE}, 32'd5);
    mtc0(CR_COUNT, 32'd0);
    repeat (9) step();
    rd("cause_pre_ti", {3'd0, CR_CAUSE}, 32'h0);
    step();
    rd("cause_ti", {3'd0, CR_CAUSE}, 32'h4000_0000);
    step();
    rd("cause_ti_ip7", {3'd0, CR_CAUSE}, 32'h4000_8000);
    mtc0(CR_STATUS, 32'h0000_8001);
    rd("status_wr", {3'd0, CR_STATUS}, 32'h0040_8001);
    check("intp_timer", {31'd0, int_pending}, 32'h1);
    mtc0(CR_CAUSE, 32'hFFFF_FFFF);
    rd("cause_wmask", {3'd0, CR_CAUSE}, 32'h4000_8300);
    mtc0(CR_COMPARE, 32'hFFFF_0000);
    rd("cause_ti_clr", {3'd0, CR_CAUSE}, 32'h0000_8300);
    step();
    rd("cause_ip7_clr", {3'd0, CR_CAUSE}, 32'h0000_0300);
    check("intp_cleared", {31'd0, int_pending}, 32'h0);
    mtc0(CR_CAUSE, 32'h0);
    ext_int_in = 6'h01;
    step();
    rd("cause_hwint", {3'd0, CR_CAUSE}, 32'h0000_0400);
    mtc0(CR_STATUS, 32'h0000_8401);
    check("intp_hwint", {31'd0, int_pending}, 32'h1);
    ext_int_in = 6'h00;
    step(); step();
    check("intp_hw_gone", {31'd0, int_pending}, 32'h0);

    // Exception in a delay slot
    ws_ex = 1'b1; ws_exccode = EXCCODE_ADEL; ws_pc = 32'hBFC0_0100;
    ws_bd = 1'b1; ws_badvaddr = 32'h1;
    #1;
    check("ex1_target", flush_target, 32'hBFC0_0380);
    check("ex1_flags", flags(), 32'h4);
    check("tlb_op", {31'd0, flush_tlb_op}, 32'h0);
    step();
    ws_ex = 1'b0; ws_bd = 1'b0;
    rd("ex1_epc", {3'd0, CR_EPC}, 32'hBFC0_00FC);
    rd("ex1_badva", {3'd0, CR_BADVADDR}, 32'h1);
    rd("ex1_cause", {3'd0, CR_CAUSE}, 32'h8000_0010);
    rd("ex1_status", {3'd0, CR_STATUS}, 32'h0040_8403);

    // Nested exception keeps EPC/BD
    ws_ex = 1'b1; ws_exccode = EXCCODE_SYS; ws_pc = 32'h8000_1000;
    ws_badvaddr = 32'hDEAD;
    #1;
    check("ex2_target", flush_target, 32'hBFC0_0380);
    step();
    ws_ex = 1'b0;
    rd("ex2_epc", {3'd0, CR_EPC}, 32'hBFC0_00FC);
    rd("ex2_badva", {3'd0, CR_BADVADDR}, 32'h1);
    rd("ex2_cause", {3'd0, CR_CAUSE}, 32'h8000_0020);

    // ERET
    ws_eret_flush = 1'b1;
    #1;
    check("eret_flags", flags(), 32'h2);
    check("eret_target", flush_target, 32'hBFC0_00FC);
    step();
    ws_eret_flush = 1'b0;
    rd("eret_status", {3'd0, CR_STATUS}, 32'h0040_8401);

    // TLB refill vectors, then ex+eret together
    ws_ex = 1'b1; ws_tlb_refill = 1'b1; ws_exccode = EXCCODE_TLBL;
    ws_pc = 32'h8000_2000; ws_badvaddr = 32'h1000;
    #1;
    check("refill_target", flush_target, 32'hBFC0_0200);
    check("refill_flags", flags(), 32'h5);
    step();
    ws_eret_flush = 1'b1; ws_pc = 32'h8000_3000; ws_badvaddr = 32'h2000;
    #1;
    check("refill_exl_target", flush_target, 32'hBFC0_0380);
    check("ex_eret_flags", flags(), 32'h5);
    step();
    ws_ex = 1'b0; ws_eret_flush = 1'b0; ws_tlb_refill = 1'b0;
    rd("ex_eret_status", {3'd0, CR_STATUS}, 32'h0040_8403);
    rd("refill_epc", {3'd0, CR_EPC}, 32'h8000_2000);
    rd("refill_badva", {3'd0, CR_BADVADDR}, 32'h2000);
    rd("refill_cause", {3'd0, CR_CAUSE}, 32'h0000_0008);
    ws_eret_flush = 1'b1;
    step();
    ws_eret_flush = 1'b0;

    // EPC R/W, BadVAddr read-only, ex beats MTC0
    mtc0(CR_EPC, 32'h1234);
    rd("epc_wr", {3'd0, CR_EPC}, 32'h1234);
    mtc0(CR_BADVADDR, 32'h5555);
    rd("badva_ro", {3'd0, CR_BADVADDR}, 32'h2000);
    ws_ex = 1'b1; ws_exccode = EXCCODE_INT; ws_pc = 32'h8000_0000;
    mtc0(CR_EPC, 32'hAAAA);
    ws_ex = 1'b0;
    rd("ex_beats_wr", {3'd0, CR_EPC}, 32'h8000_0000);

    // Count wrap, write-induced match, compare write over match
    mtc0(CR_COUNT, 32'hFFFF_FFFF);
    step();
    rd("count_hold", {3'd0, CR_COUNT}, 32'hFFFF_FFFF);
    step();
    rd("count_wrap", {3'd0, CR_COUNT}, 32'h0);
    mtc0(CR_COMPARE, 32'h50);
    ti_chk("ti_cmp_wr", 1'b0);
    mtc0(CR_COUNT, 32'h50);
    ti_chk("ti_count_wr_match", 1'b1);
    mtc0(CR_COMPARE, 32'h200);
    mtc0(CR_COUNT, 32'h1FF);
    step();
    mtc0(CR_COMPARE, 32'h300);
    ti_chk("ti_cmp_wr_beats_match", 1'b0);
    rd("count_at_match", {3'd0, CR_COUNT}, 32'h200);

    // Asynchronous reset mid-run
    resetn = 1'b0;
    #1;
    check("intp_async_rst", {31'd0, int_pending}, 32'h0);
    #1;
    resetn = 1'b1;
    rd("status_after_rst", {3'd0, CR_STATUS}, 32'h0040_0000);
    rd("epc_after_rst", {3'd0, CR_EPC}, 32'h0);
    rd("count_after_rst", {3'd0, CR_COUNT}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
